// File: rtl/dec_scan_pkg.sv
// Shared types for the scanning decoder: command modes, sequencer states and
// the output-width helper used to size the one-cold bus.
package dec_scan_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_SCAN_UP   = 2'b01,
        MODE_SCAN_DOWN = 2'b10,
        MODE_OFF       = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SCAN
    } state_t;

    function automatic int out_width(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational SEL_W-to-2^SEL_W active-low decoder; all outputs stay high
// unless the enable is asserted.
module dec_onehot
    import dec_scan_pkg::*;
#(
    parameter  int SEL_W = 3,
    localparam int OUT_W = out_width(SEL_W)
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [OUT_W-1:0] y_n
);

    always_comb begin
        y_n = '1;
        if (en) begin
            y_n[sel] = 1'b0;
        end
    end

endmodule

// File: rtl/dec_scan_seq.sv
// Registered one-cold decoder with a valid/ready command port: DIRECT holds an
// index, SCAN_UP/SCAN_DOWN sweep every index once with a programmable dwell.
module dec_scan_seq
    import dec_scan_pkg::*;
#(
    parameter  int SEL_W   = 3,
    parameter  int DWELL_W = 4,
    localparam int OUT_W   = out_width(SEL_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_g1,
    input  logic               en_g2a_n,
    input  logic               en_g2b_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic [SEL_W-1:0]   cmd_sel,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               abort,
    output logic [OUT_W-1:0]   y_n,
    output logic [SEL_W-1:0]   sel_cur,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    localparam logic [SEL_W-1:0] SEL_MAX = {SEL_W{1'b1}};
    localparam logic [SEL_W:0]   POS_END = (SEL_W + 1)'(OUT_W);

    state_t             state, state_d;
    mode_t              mode;
    logic [SEL_W-1:0]   sel_d;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_d;
    logic [DWELL_W-1:0] dwell_ld, dwell_ld_d;
    logic [SEL_W:0]     pos_cnt, pos_cnt_d, pos_next;
    logic               scan_down, scan_down_d;
    logic               done_d, wrap_d;
    logic               en, accept, dec_en;
    logic [OUT_W-1:0]   y_n_d;

    assign en        = en_g1 & ~en_g2a_n & ~en_g2b_n;
    assign cmd_ready = ~abort & (state != ST_SCAN);
    assign accept    = cmd_valid & cmd_ready;
    assign mode      = mode_t'(cmd_mode);

    // The terminal step leaves the index alone and drops to IDLE instead of stepping.
    always_comb begin
        state_d     = state;
        sel_d       = sel_cur;
        dwell_cnt_d = dwell_cnt;
        dwell_ld_d  = dwell_ld;
        pos_cnt_d   = pos_cnt;
        scan_down_d = scan_down;
        done_d      = 1'b0;
        wrap_d      = 1'b0;
        pos_next    = pos_cnt + 1'b1;

        if (abort) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            case (mode)
                MODE_DIRECT: begin
                    state_d = ST_HOLD;
                    sel_d   = cmd_sel;
                end
                MODE_SCAN_UP, MODE_SCAN_DOWN: begin
                    state_d     = ST_SCAN;
                    sel_d       = cmd_sel;
                    dwell_cnt_d = cmd_dwell;
                    dwell_ld_d  = cmd_dwell;
                    pos_cnt_d   = '0;
                    scan_down_d = (mode == MODE_SCAN_DOWN);
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state == ST_SCAN && en) begin
            if (dwell_cnt != '0) begin
                dwell_cnt_d = dwell_cnt - 1'b1;
            end else if (pos_next == POS_END) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                sel_d       = scan_down ? sel_cur - 1'b1 : sel_cur + 1'b1;
                dwell_cnt_d = dwell_ld;
                pos_cnt_d   = pos_next;
                wrap_d      = scan_down ? (sel_cur == '0) : (sel_cur == SEL_MAX);
            end
        end
    end

    assign dec_en = en & (state_d != ST_IDLE);

    dec_onehot #(
        .SEL_W (SEL_W)
    ) u_dec (
        .sel (sel_d),
        .en  (dec_en),
        .y_n (y_n_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel_cur   <= '0;
            dwell_cnt <= '0;
            dwell_ld  <= '0;
            pos_cnt   <= '0;
            scan_down <= 1'b0;
            y_n       <= '1;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_d;
            sel_cur   <= sel_d;
            dwell_cnt <= dwell_cnt_d;
            dwell_ld  <= dwell_ld_d;
            pos_cnt   <= pos_cnt_d;
            scan_down <= scan_down_d;
            y_n       <= y_n_d;
            busy      <= (state_d == ST_SCAN);
            done      <= done_d;
            wrap      <= wrap_d;
        end
    end

endmodule

// File: tb/tb_dec_scan_seq.sv
// Directed bench for dec_scan_seq: stimulus queues the expected outputs of the
// next cycle and an independent monitor pops and compares them.
module tb_dec_scan_seq;
    import dec_scan_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_g1, en_g2a_n, en_g2b_n;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_mode;
    logic [2:0] cmd_sel;
    logic [3:0] cmd_dwell;
    logic       abort;
    logic [7:0] y_n;
    logic [2:0] sel_cur;
    logic       busy, done, wrap;

    typedef struct {
        logic [7:0] y;
        logic       done;
        logic       wrap;
        logic       busy;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dec_scan_seq #(
        .SEL_W   (3),
        .DWELL_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_g1     (en_g1),
        .en_g2a_n  (en_g2a_n),
        .en_g2b_n  (en_g2b_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_sel   (cmd_sel),
        .cmd_dwell (cmd_dwell),
        .abort     (abort),
        .y_n       (y_n),
        .sel_cur   (sel_cur),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    function automatic logic [7:0] onecold(input logic [2:0] idx);
        return ~(8'h01 << idx);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [2:0] s,
                                 input logic [3:0] dw, input logic ab);
        cmd_valid = v;
        cmd_mode  = m;
        cmd_sel   = s;
        cmd_dwell = dw;
        abort     = ab;
    endtask

    // Queue what the DUT must show after the coming rising edge, then let it happen.
    task automatic tick(input logic [7:0] y, input logic d, input logic w, input logic b,
                        input string name);
        exp_t e;
        e.y    = y;
        e.done = d;
        e.wrap = w;
        e.busy = b;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({e.name, ".y_n"},  y_n,  e.y);
            checkOutput({e.name, ".done"}, done, e.done);
            checkOutput({e.name, ".wrap"}, wrap, e.wrap);
            checkOutput({e.name, ".busy"}, busy, e.busy);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n    = 1'b1;
        en_g1    = 1'b1;
        en_g2a_n = 1'b0;
        en_g2b_n = 1'b0;
        applyStimulus(1'b0, MODE_OFF, 3'd0, 4'd0, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset.y_n", y_n, 8'hFF);
        checkOutput("reset.sel_cur", sel_cur, 0);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.wrap", wrap, 0);
        checkOutput("reset.cmd_ready", cmd_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(8'hFF, 0, 0, 0, "idle");

        applyStimulus(1'b1, MODE_DIRECT, 3'd5, 4'd0, 1'b0);
        tick(8'hDF, 0, 0, 0, "direct_accept");
        applyStimulus(1'b0, MODE_DIRECT, 3'd5, 4'd0, 1'b0);
        tick(8'hDF, 0, 0, 0, "direct_hold");
        tick(8'hDF, 0, 0, 0, "direct_hold");
        en_g2a_n = 1'b1;
        tick(8'hFF, 0, 0, 0, "direct_g2a_off");
        en_g2a_n = 1'b0;
        tick(8'hDF, 0, 0, 0, "direct_g2a_on");
        en_g2b_n = 1'b1;
        tick(8'hFF, 0, 0, 0, "direct_g2b_off");
        en_g2b_n = 1'b0;
        tick(8'hDF, 0, 0, 0, "direct_g2b_on");
        checkOutput("direct.sel_cur", sel_cur, 5);

        applyStimulus(1'b1, MODE_SCAN_UP, 3'd6, 4'd1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick(onecold(3'(6 + i / 2)), 0, (i == 4), 1, "scan_up_dwell1");
            if (i == 0) applyStimulus(1'b0, MODE_OFF, 3'd0, 4'd0, 1'b0);
        end
        tick(8'hFF, 1, 0, 0, "scan_up_done");
        checkOutput("scan_up_done.cmd_ready", cmd_ready, 1);

        applyStimulus(1'b1, MODE_SCAN_DOWN, 3'd0, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(onecold(3'(8 - i)), 0, (i == 1), 1, "scan_down");
            if (i == 0) applyStimulus(1'b0, MODE_OFF, 3'd0, 4'd0, 1'b0);
        end
        tick(8'hFF, 1, 0, 0, "scan_down_done");

        applyStimulus(1'b1, MODE_SCAN_UP, 3'd0, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(onecold(3'(i)), 0, 0, 1, "scan_up_from0");
            if (i == 0) applyStimulus(1'b0, MODE_OFF, 3'd0, 4'd0, 1'b0);
        end
        tick(8'hFF, 1, 0, 0, "scan_up_from0_done");

        applyStimulus(1'b1, MODE_SCAN_UP, 3'd2, 4'd0, 1'b0);
        tick(onecold(3'd2), 0, 0, 1, "pause_start");
        applyStimulus(1'b0, MODE_OFF, 3'd0, 4'd0, 1'b0);
        en_g1 = 1'b0;
        tick(8'hFF, 0, 0, 1, "pause_off");
        tick(8'hFF, 0, 0, 1, "pause_off");
        en_g1 = 1'b1;
        checkOutput("pause.sel_cur", sel_cur, 2);
        for (int i = 3; i < 10; i++) begin
            tick(onecold(3'(i)), 0, (i == 8), 1, "pause_resume");
        end
        tick(8'hFF, 1, 0, 0, "pause_done");

        applyStimulus(1'b1, MODE_SCAN_UP, 3'd4, 4'd2, 1'b0);
        tick(onecold(3'd4), 0, 0, 1, "abort_scan_start");
        applyStimulus(1'b0, MODE_OFF, 3'd0, 4'd0, 1'b0);
        tick(onecold(3'd4), 0, 0, 1, "abort_scan_dwell");
        tick(onecold(3'd4), 0, 0, 1, "abort_scan_dwell");
        applyStimulus(1'b1, MODE_DIRECT, 3'd1, 4'd0, 1'b1);
        #1 checkOutput("abort_scan.cmd_ready", cmd_ready, 0);
        tick(8'hFF, 0, 0, 0, "abort_scan");
        applyStimulus(1'b1, MODE_DIRECT, 3'd1, 4'd0, 1'b0);
        #1 checkOutput("post_abort.cmd_ready", cmd_ready, 1);
        tick(onecold(3'd1), 0, 0, 0, "post_abort_accept");
        applyStimulus(1'b0, MODE_OFF, 3'd0, 4'd0, 1'b0);
        tick(onecold(3'd1), 0, 0, 0, "post_abort_hold");

        applyStimulus(1'b1, MODE_DIRECT, 3'd6, 4'd0, 1'b1);
        #1 checkOutput("abort_hold.cmd_ready", cmd_ready, 0);
        tick(8'hFF, 0, 0, 0, "abort_hold");
        applyStimulus(1'b0, MODE_DIRECT, 3'd6, 4'd0, 1'b0);
        tick(8'hFF, 0, 0, 0, "abort_hold_idle");

        applyStimulus(1'b1, MODE_DIRECT, 3'd7, 4'd0, 1'b0);
        tick(8'h7F, 0, 0, 0, "direct7");
        applyStimulus(1'b1, MODE_OFF, 3'd7, 4'd0, 1'b0);
        tick(8'hFF, 0, 0, 0, "off");
        applyStimulus(1'b0, MODE_OFF, 3'd0, 4'd0, 1'b0);
        tick(8'hFF, 0, 0, 0, "off_idle");

        applyStimulus(1'b1, MODE_SCAN_UP, 3'd3, 4'd3, 1'b0);
        tick(onecold(3'd3), 0, 0, 1, "rst_scan_start");
        applyStimulus(1'b0, MODE_OFF, 3'd0, 4'd0, 1'b0);
        tick(onecold(3'd3), 0, 0, 1, "rst_scan_dwell");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst.y_n", y_n, 8'hFF);
        checkOutput("async_rst.busy", busy, 0);
        checkOutput("async_rst.cmd_ready", cmd_ready, 1);
        checkOutput("async_rst.sel_cur", sel_cur, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(8'hFF, 0, 0, 0, "async_rst_idle");

        @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
